// File: rtl/trigger_pkg.sv
// Shared definitions for the multi-stage capture trigger.
//   trg_state_e  : sequencer state encoding (IDLE / RUN / DONE)
//   *_DEF        : default sizing used by the trigger blocks
//   slice_lsb()  : base bit of stage slice s in a packed per-stage config bus
//   hit_bit()    : edge/level hit for one data bit, applied bitwise across a sample
package trigger_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } trg_state_e;

   localparam int unsigned SDW_DEF = 32;
   localparam int unsigned TSN_DEF = 4;
   localparam int unsigned CNW_DEF = 16;
   localparam int unsigned SIW_DEF = 4;

   function automatic int unsigned slice_lsb(input int unsigned s, input int unsigned w);
      return s * w;
   endfunction

   // d = delayed (previous) bit, c = current bit; each mask selects one of the
   // four prev/cur combinations as a hit.
   function automatic logic hit_bit(input logic d, input logic c,
                                    input logic m00, input logic m01,
                                    input logic m10, input logic m11);
      return (~d & ~c & m00) | (~d & c & m01) | (d & ~c & m10) | (d & c & m11);
   endfunction

endpackage

// File: rtl/trigger_stage_match.sv
// Combinational comparator for one trigger stage.
//   d, c      : previous and current sample
//   m00..m11  : per-bit hit masks for each prev/cur combination
//   mode      : 0 = any bit hit matches, 1 = every bit must hit
//   match     : stage condition met for this sample pair
module trigger_stage_match
   import trigger_pkg::*;
#(
   parameter int unsigned SDW = SDW_DEF
) (
   input  logic [SDW-1:0] d,
   input  logic [SDW-1:0] c,
   input  logic [SDW-1:0] m00,
   input  logic [SDW-1:0] m01,
   input  logic [SDW-1:0] m10,
   input  logic [SDW-1:0] m11,
   input  logic           mode,
   output logic           match
);

   logic [SDW-1:0] hits;

   for (genvar i = 0; i < SDW; i++) begin : g_bit
      assign hits[i] = hit_bit(d[i], c[i], m00[i], m01[i], m10[i], m11[i]);
   end

   // An all-zero mask set gives no hits: OR never fires, AND fires only when
   // every bit is covered by some mask.
   assign match = mode ? (&hits) : (|hits);

endmodule

// File: rtl/trigger_sequencer.sv
// Multi-stage trigger between the sample stream and the capture controller.
// TSN comparator stages are walked in order; each must see cfg_cnt+1 matching
// transfers (cumulative) before the next stage takes over. sts_trg pulses once
// when the last stage completes.
//   clk, rst_n             : clock, async active-low reset
//   ctl_arm, ctl_abort     : start at stage 0 / return to idle (abort wins)
//   cfg_mod, cfg_0_0..1_1  : per-stage mode and hit masks, slice s at [s*W +: W]
//   cfg_cnt                : per-stage required hits minus one
//   sti_transfer, sti_tdata: accepted sample stream
//   sts_armed/stage/cnt    : sequence running, current stage, hits in stage
//   sts_trg, sts_done      : one-cycle trigger pulse, sticky done
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | not armed; samples only refresh the delay register
// RUN     | walking the stages; evaluates once the delay register is primed
// DONE    | last stage completed; sts_done held until arm or abort
module trigger_sequencer
   import trigger_pkg::*;
#(
   parameter int unsigned SDW = SDW_DEF,
   parameter int unsigned TSN = TSN_DEF,
   parameter int unsigned CNW = CNW_DEF,
   parameter int unsigned SIW = SIW_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ctl_arm,
   input  logic             ctl_abort,
   input  logic [TSN-1:0]   cfg_mod,
   input  logic [TSN*SDW-1:0] cfg_0_0,
   input  logic [TSN*SDW-1:0] cfg_0_1,
   input  logic [TSN*SDW-1:0] cfg_1_0,
   input  logic [TSN*SDW-1:0] cfg_1_1,
   input  logic [TSN*CNW-1:0] cfg_cnt,
   input  logic             sti_transfer,
   input  logic [SDW-1:0]   sti_tdata,
   output logic             sts_armed,
   output logic [SIW-1:0]   sts_stage,
   output logic [CNW-1:0]   sts_cnt,
   output logic             sts_trg,
   output logic             sts_done
);

   trg_state_e     state;
   logic [SDW-1:0] dly_tdata;
   logic           dly_vld;
   logic [TSN-1:0] stage_match;
   logic           sel_match;
   logic [CNW-1:0] sel_cnt;
   logic           last_stage;
   logic           eval_hit;

   for (genvar s = 0; s < TSN; s++) begin : g_stage
      trigger_stage_match #(
         .SDW (SDW)
      ) u_match (
         .d     (dly_tdata),
         .c     (sti_tdata),
         .m00   (cfg_0_0[slice_lsb(s, SDW) +: SDW]),
         .m01   (cfg_0_1[slice_lsb(s, SDW) +: SDW]),
         .m10   (cfg_1_0[slice_lsb(s, SDW) +: SDW]),
         .m11   (cfg_1_1[slice_lsb(s, SDW) +: SDW]),
         .mode  (cfg_mod[s]),
         .match (stage_match[s])
      );
   end

   // Only the active stage is looked at; sts_stage never exceeds TSN-1.
   always_comb begin
      sel_match = 1'b0;
      sel_cnt   = '0;
      for (int s = 0; s < TSN; s++) begin
         if (sts_stage == SIW'(s)) begin
            sel_match = stage_match[s];
            sel_cnt   = cfg_cnt[s*CNW +: CNW];
         end
      end
   end

   assign last_stage = (sts_stage == SIW'(TSN - 1));
   assign eval_hit   = sti_transfer & dly_vld & sel_match;
   assign sts_armed  = (state == ST_RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         sts_stage <= '0;
         sts_cnt   <= '0;
         sts_trg   <= 1'b0;
         sts_done  <= 1'b0;
         dly_tdata <= '0;
         dly_vld   <= 1'b0;
      end else begin
         sts_trg <= 1'b0;
         if (sti_transfer) begin
            dly_tdata <= sti_tdata;
         end
         if (ctl_abort) begin
            state     <= ST_IDLE;
            sts_stage <= '0;
            sts_cnt   <= '0;
            sts_done  <= 1'b0;
            dly_vld   <= 1'b0;
         end else if (ctl_arm) begin
            // Also a restart when already running: the sample in this cycle
            // is not evaluated and the next one only primes the delay.
            state     <= ST_RUN;
            sts_stage <= '0;
            sts_cnt   <= '0;
            sts_done  <= 1'b0;
            dly_vld   <= 1'b0;
         end else begin
            case (state)
               ST_RUN: begin
                  if (sti_transfer) begin
                     dly_vld <= 1'b1;
                  end
                  if (eval_hit) begin
                     if (sts_cnt == sel_cnt) begin
                        if (last_stage) begin
                           state    <= ST_DONE;
                           sts_trg  <= 1'b1;
                           sts_done <= 1'b1;
                        end else begin
                           sts_stage <= sts_stage + SIW'(1);
                           sts_cnt   <= '0;
                        end
                     end else begin
                        // Terminal compare above stops the count at cfg_cnt,
                        // so all-ones completes instead of wrapping.
                        sts_cnt <= sts_cnt + CNW'(1);
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_trigger_sequencer.sv
module tb_trigger_sequencer;

   localparam int SDW = 32;
   localparam int TSN = 4;
   localparam int CNW = 4;
   localparam int SIW = 2;
   localparam int VW  = SIW + CNW + 3;

   logic               clk;
   logic               rst_n;
   logic               ctl_arm;
   logic               ctl_abort;
   logic [TSN-1:0]     cfg_mod;
   logic [TSN*SDW-1:0] cfg_0_0;
   logic [TSN*SDW-1:0] cfg_0_1;
   logic [TSN*SDW-1:0] cfg_1_0;
   logic [TSN*SDW-1:0] cfg_1_1;
   logic [TSN*CNW-1:0] cfg_cnt;
   logic               sti_transfer;
   logic [SDW-1:0]     sti_tdata;
   logic               sts_armed;
   logic [SIW-1:0]     sts_stage;
   logic [CNW-1:0]     sts_cnt;
   logic               sts_trg;
   logic               sts_done;

   logic [SDW-1:0] m00_a [TSN];
   logic [SDW-1:0] m01_a [TSN];
   logic [SDW-1:0] m10_a [TSN];
   logic [SDW-1:0] m11_a [TSN];
   logic [CNW-1:0] cnt_a [TSN];
   logic           mod_a [TSN];

   // reference model state
   bit             m_run, m_done, m_trg, m_primed;
   int             m_stage, m_cnt;
   logic [SDW-1:0] m_prev;

   int n_chk;
   int n_fail;

   wire [VW-1:0] dut_vec = {sts_armed, sts_stage, sts_cnt, sts_trg, sts_done};

   trigger_sequencer #(
      .SDW (SDW), .TSN (TSN), .CNW (CNW), .SIW (SIW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ctl_arm      (ctl_arm),
      .ctl_abort    (ctl_abort),
      .cfg_mod      (cfg_mod),
      .cfg_0_0      (cfg_0_0),
      .cfg_0_1      (cfg_0_1),
      .cfg_1_0      (cfg_1_0),
      .cfg_1_1      (cfg_1_1),
      .cfg_cnt      (cfg_cnt),
      .sti_transfer (sti_transfer),
      .sti_tdata    (sti_tdata),
      .sts_armed    (sts_armed),
      .sts_stage    (sts_stage),
      .sts_cnt      (sts_cnt),
      .sts_trg      (sts_trg),
      .sts_done     (sts_done)
   );

   for (genvar s = 0; s < TSN; s++) begin : g_pack
      assign cfg_mod[s]                = mod_a[s];
      assign cfg_0_0[s*SDW +: SDW]     = m00_a[s];
      assign cfg_0_1[s*SDW +: SDW]     = m01_a[s];
      assign cfg_1_0[s*SDW +: SDW]     = m10_a[s];
      assign cfg_1_1[s*SDW +: SDW]     = m11_a[s];
      assign cfg_cnt[s*CNW +: CNW]     = cnt_a[s];
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   function automatic bit model_match(input int s, input logic [SDW-1:0] d, input logic [SDW-1:0] c);
      int hits = 0;
      for (int i = 0; i < SDW; i++) begin
         case ({d[i], c[i]})
            2'b00:   hits += int'(m00_a[s][i]);
            2'b01:   hits += int'(m01_a[s][i]);
            2'b10:   hits += int'(m10_a[s][i]);
            default: hits += int'(m11_a[s][i]);
         endcase
      end
      return mod_a[s] ? (hits == SDW) : (hits > 0);
   endfunction

   task automatic model_reset();
      m_run = 0; m_done = 0; m_trg = 0; m_primed = 0;
      m_stage = 0; m_cnt = 0; m_prev = '0;
   endtask

   task automatic model_step(input bit arm, input bit abort, input bit xfer, input logic [SDW-1:0] data);
      m_trg = 0;
      if (abort) begin
         m_run = 0; m_done = 0; m_stage = 0; m_cnt = 0; m_primed = 0;
      end else if (arm) begin
         m_run = 1; m_done = 0; m_stage = 0; m_cnt = 0; m_primed = 0;
      end else if (m_run && xfer) begin
         if (m_primed && model_match(m_stage, m_prev, data)) begin
            if (m_cnt == int'(cnt_a[m_stage])) begin
               if (m_stage == TSN - 1) begin
                  m_run = 0; m_done = 1; m_trg = 1;
               end else begin
                  m_stage++; m_cnt = 0;
               end
            end else begin
               m_cnt++;
            end
         end
         m_primed = 1;
      end
      if (xfer) m_prev = data;
   endtask

   function automatic logic [VW-1:0] exp_vec();
      return {m_run, SIW'(m_stage), CNW'(m_cnt), m_trg, m_done};
   endfunction

   // ---------------- stimulus plumbing ----------------
   // Called at a falling edge; returns at the next falling edge with the
   // model advanced by the same clock edge the DUT saw.
   task automatic cyc(input bit arm, input bit abort, input bit xfer, input logic [SDW-1:0] data);
      ctl_arm = arm; ctl_abort = abort; sti_transfer = xfer; sti_tdata = data;
      @(posedge clk);
      model_step(arm, abort, xfer, data);
      @(negedge clk);
      ctl_arm = 1'b0; ctl_abort = 1'b0; sti_transfer = 1'b0;
   endtask

   task automatic set_always(input int s, input logic [CNW-1:0] cnt);
      m00_a[s] = '1; m01_a[s] = '1; m10_a[s] = '1; m11_a[s] = '1;
      mod_a[s] = 1'b1; cnt_a[s] = cnt;
   endtask

   task automatic set_off(input int s);
      m00_a[s] = '0; m01_a[s] = '0; m10_a[s] = '0; m11_a[s] = '0;
      mod_a[s] = 1'b0; cnt_a[s] = '0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #3;
      n_chk++;
      if (dut_vec !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got %h want 0", dut_vec);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 1, $urandom);
         n_chk++;
         if (dut_vec !== exp_vec() || sts_armed !== 1'b0) begin
            n_fail++; $display("FAIL idle_ignores_xfer: got %h want %h", dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_single_edge();
      logic [SDW-1:0] seq [6];
      seq = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1};
      for (int s = 0; s < 3; s++) set_always(s, '0);
      set_off(3);
      m01_a[3] = 32'h1;
      cyc(1, 0, 0, '0);
      for (int i = 0; i < 6; i++) begin
         cyc(0, 0, 1, seq[i]);
         n_chk++;
         if (dut_vec !== exp_vec() || sts_trg !== (i == 5)) begin
            n_fail++; $display("FAIL single_edge[%0d]: got %h want %h", i, dut_vec, exp_vec());
         end
      end
      n_chk++;
      if (sts_done !== 1'b1 || sts_armed !== 1'b0 || sts_stage !== SIW'(TSN - 1)) begin
         n_fail++; $display("FAIL single_edge_done: got %h", dut_vec);
      end
      cyc(0, 0, 1, 32'h0);
      n_chk++;
      if (sts_trg !== 1'b0 || sts_done !== 1'b1 || dut_vec !== exp_vec()) begin
         n_fail++; $display("FAIL trg_one_cycle: got %h want %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_count_stage();
      logic [SDW-1:0] seq [11];
      int             e_cnt [11];
      int             e_stg [11];
      seq   = '{32'hFF, 32'hFF, 32'h00, 32'hFF, 32'hFF, 32'h00, 32'hFF, 32'hFF, 32'h100, 32'h0, 32'h0};
      e_cnt = '{0, 1, 1, 1, 2, 2, 2, 0, 0, 0, 0};
      e_stg = '{0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 3};
      // stage 0: bits 7:0 must be held high, upper bits don't care
      m11_a[0] = '1; m00_a[0] = 32'hFFFF_FF00; m01_a[0] = 32'hFFFF_FF00; m10_a[0] = 32'hFFFF_FF00;
      mod_a[0] = 1'b1; cnt_a[0] = 4'd2;
      set_off(1);
      m01_a[1] = 32'h100;
      set_always(2, '0);
      set_always(3, '0);
      cyc(1, 0, 0, '0);
      for (int i = 0; i < 11; i++) begin
         cyc(0, 0, 1, seq[i]);
         n_chk++;
         if (dut_vec !== exp_vec() || sts_cnt !== CNW'(e_cnt[i]) || sts_stage !== SIW'(e_stg[i])
             || sts_trg !== (i == 10)) begin
            n_fail++; $display("FAIL count_stage[%0d]: got %h want %h", i, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_arm_abort();
      set_always(0, '0);
      set_off(1);
      cyc(1, 0, 0, '0);
      cyc(0, 0, 1, $urandom);
      cyc(0, 0, 1, $urandom);
      n_chk++;
      if (sts_stage !== SIW'(1) || dut_vec !== exp_vec()) begin
         n_fail++; $display("FAIL abort_setup: got %h want %h", dut_vec, exp_vec());
      end
      cyc(1, 1, 1, $urandom);
      n_chk++;
      if (sts_armed !== 1'b0 || sts_stage !== '0 || sts_trg !== 1'b0 || sts_done !== 1'b0
          || dut_vec !== exp_vec()) begin
         n_fail++; $display("FAIL arm_abort_same_cycle: got %h want %h", dut_vec, exp_vec());
      end
      for (int i = 0; i < 2; i++) begin
         cyc(0, 0, 1, $urandom);
         n_chk++;
         if (dut_vec !== exp_vec() || sts_armed !== 1'b0) begin
            n_fail++; $display("FAIL abort_stays_idle: got %h want %h", dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_rearm();
      set_always(0, '0);
      set_always(1, '0);
      set_always(2, 4'd9);
      set_off(3);
      cyc(1, 0, 0, '0);
      for (int i = 0; i < 8; i++) cyc(0, 0, 1, $urandom);
      n_chk++;
      if (sts_stage !== SIW'(2) || sts_cnt !== CNW'(5) || dut_vec !== exp_vec()) begin
         n_fail++; $display("FAIL rearm_setup: got %h want %h", dut_vec, exp_vec());
      end
      cyc(1, 0, 1, $urandom);
      n_chk++;
      if (sts_stage !== '0 || sts_cnt !== '0 || sts_armed !== 1'b1 || dut_vec !== exp_vec()) begin
         n_fail++; $display("FAIL rearm_restart: got %h want %h", dut_vec, exp_vec());
      end
      cyc(0, 0, 1, $urandom);
      n_chk++;
      if (sts_stage !== '0 || sts_cnt !== '0 || dut_vec !== exp_vec()) begin
         n_fail++; $display("FAIL rearm_prime_only: got %h want %h", dut_vec, exp_vec());
      end
      cyc(0, 0, 1, $urandom);
      n_chk++;
      if (sts_stage !== SIW'(1) || dut_vec !== exp_vec()) begin
         n_fail++; $display("FAIL rearm_first_eval: got %h want %h", dut_vec, exp_vec());
      end
      cyc(0, 1, 0, '0);
   endtask

   task automatic test_async_reset();
      for (int s = 0; s < TSN; s++) set_always(s, '0);
      cyc(1, 0, 0, '0);
      cyc(0, 0, 1, $urandom);
      cyc(0, 0, 1, $urandom);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      n_chk++;
      if (dut_vec !== '0) begin
         n_fail++; $display("FAIL async_reset: got %h want 0", dut_vec);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 1, $urandom);
         n_chk++;
         if (dut_vec !== '0 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL post_reset_idle: got %h want %h", dut_vec, exp_vec());
         end
      end
      cyc(1, 0, 0, '0);
      cyc(0, 0, 1, $urandom);
      cyc(0, 0, 1, $urandom);
      n_chk++;
      if (sts_stage !== SIW'(1) || dut_vec !== exp_vec()) begin
         n_fail++; $display("FAIL post_reset_rearm: got %h want %h", dut_vec, exp_vec());
      end
      cyc(0, 1, 0, '0);
   endtask

   task automatic test_max_count();
      for (int s = 0; s < 3; s++) set_always(s, '0);
      set_always(3, '1);
      cyc(1, 0, 0, '0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, $urandom);
      for (int i = 0; i < 16; i++) begin
         cyc(0, 0, 1, $urandom);
         n_chk++;
         if (dut_vec !== exp_vec() || sts_trg !== (i == 15)
             || sts_cnt !== CNW'((i < 15) ? i + 1 : 15)) begin
            n_fail++; $display("FAIL max_count[%0d]: got %h want %h", i, dut_vec, exp_vec());
         end
      end
      n_chk++;
      if (sts_done !== 1'b1 || sts_stage !== SIW'(TSN - 1)) begin
         n_fail++; $display("FAIL max_count_done: got %h", dut_vec);
      end
      cyc(0, 1, 0, '0);
   endtask

   task automatic test_random();
      logic [SDW-1:0] d;
      bit             arm, abort, xfer;
      for (int r = 0; r < 8; r++) begin
         for (int s = 0; s < TSN; s++) begin
            mod_a[s] = 1'($urandom);
            cnt_a[s] = CNW'($urandom_range(0, 2));
            if (mod_a[s]) begin
               m00_a[s] = {{(SDW-4){1'b1}}, 4'($urandom)};
               m01_a[s] = {{(SDW-4){1'b1}}, 4'($urandom)};
               m10_a[s] = {{(SDW-4){1'b1}}, 4'($urandom)};
               m11_a[s] = {{(SDW-4){1'b1}}, 4'($urandom)};
            end else begin
               m00_a[s] = $urandom & $urandom & $urandom;
               m01_a[s] = $urandom & $urandom & $urandom;
               m10_a[s] = $urandom & $urandom & $urandom;
               m11_a[s] = $urandom & $urandom & $urandom;
            end
         end
         cyc(1, 0, 0, '0);
         for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
               0:       d = '0;
               1:       d = '1;
               2:       d = $urandom;
               default: d = m_prev ^ (SDW'(1) << $urandom_range(0, SDW - 1));
            endcase
            arm   = (!m_run && $urandom_range(0, 7) == 0) || ($urandom_range(0, 49) == 0);
            abort = ($urandom_range(0, 79) == 0);
            xfer  = ($urandom_range(0, 9) < 7);
            cyc(arm, abort, xfer, d);
            n_chk++;
            if (dut_vec !== exp_vec()) begin
               n_fail++; $display("FAIL random[%0d.%0d]: got %h want %h", r, i, dut_vec, exp_vec());
            end
         end
         cyc(0, 1, 0, '0);
      end
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      rst_n = 1'b0;
      ctl_arm = 1'b0;
      ctl_abort = 1'b0;
      sti_transfer = 1'b0;
      sti_tdata = '0;
      for (int s = 0; s < TSN; s++) set_off(s);
      model_reset();
      test_reset();
      test_single_edge();
      cyc(0, 1, 0, '0);
      test_count_stage();
      cyc(0, 1, 0, '0);
      test_arm_abort();
      test_rearm();
      test_async_reset();
      test_max_count();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/trigger_sequencer.md
Name: trigger_sequencer

Overview:
- Multi-stage trigger for the logic-analyser capture path, sitting between the sample stream and the capture controller.
- Holds TSN independent edge/level comparator stages. Each stage has its own AND/OR mode and a required occurrence count.
- Stages are evaluated in sequence. `sts_trg` pulses when the last stage completes.
- Generalises the single-stage comparator with stage count, occurrence counting, arm/abort control and a priming rule for the delayed sample.

Parameters:
- SDW, 32, sample data width.
- TSN, 4, number of sequential trigger stages (1..16).
- CNW, 16, occurrence counter width per stage.
- SIW, 4, stage index width; must satisfy 2**SIW >= TSN.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ctl_arm  in  1  single-cycle pulse: start sequence at stage 0.
- ctl_abort  in  1  single-cycle pulse: return to idle.
- cfg_mod  in  TSN  per stage: 0 = OR of bit hits, 1 = AND of bit hits.
- cfg_0_0  in  TSN*SDW  per stage: bit hit when prev=0, cur=0.
- cfg_0_1  in  TSN*SDW  per stage: bit hit when prev=0, cur=1.
- cfg_1_0  in  TSN*SDW  per stage: bit hit when prev=1, cur=0.
- cfg_1_1  in  TSN*SDW  per stage: bit hit when prev=1, cur=1.
- cfg_cnt  in  TSN*CNW  per stage: hits required minus one.
- sti_transfer  in  1  sample valid and accepted.
- sti_tdata  in  SDW  sample data.
- sts_armed  out  1  high while the sequence is running.
- sts_stage  out  SIW  current stage index.
- sts_cnt  out  CNW  hits counted in the current stage.
- sts_trg  out  1  one-cycle trigger pulse.
- sts_done  out  1  high after trigger, until the next arm or abort.

Behaviour:
- Reset (rst_n low, async): state IDLE.
  - All outputs 0: sts_armed, sts_stage, sts_cnt, sts_trg, sts_done.
  - dly_tdata = 0, dly_vld = 0.
- Stage slice s of every packed config port occupies bits [s*W +: W].
- Config is static while armed. It is read live and is not latched.
- FSM states: IDLE, RUN, DONE.
  - IDLE --ctl_arm--> RUN.
  - RUN --last-stage completion--> DONE.
  - RUN or DONE --ctl_abort--> IDLE.
  - DONE --ctl_arm--> RUN.
- Priority when pulses coincide: ctl_abort > ctl_arm > stage evaluation in the same cycle.
- ctl_arm while RUN: restart at stage 0 with sts_cnt = 0. The sample in that cycle is not evaluated.
- On every arm:
  - sts_stage = 0, sts_cnt = 0, dly_vld = 0.
  - sts_done = 0.
- Delay register:
  - On sti_transfer in any state: dly_tdata <= sti_tdata.
  - In RUN, dly_vld <= 1 on sti_transfer.
  - The first transfer after arm only primes dly_tdata and is never evaluated.
- Per-stage per-bit hit: (~d&~c&c00) | (~d&c&c01) | (d&~c&c10) | (d&c&c11), where d = dly_tdata and c = sti_tdata.
- Stage match: &hits if cfg_mod[s], else |hits.
- All-zero masks:
  - OR mode never matches.
  - AND mode never matches unless all bits are masked in.
- Evaluation happens only in RUN when sti_transfer and dly_vld are both set. Only stage sts_stage is evaluated.
- On match with sts_cnt == cfg_cnt[s], the stage completes:
  - If s < TSN-1: sts_stage <= s+1, sts_cnt <= 0.
  - If s == TSN-1: state DONE, sts_trg = 1 for exactly one cycle, sts_done = 1, sts_stage holds TSN-1.
- On match otherwise: sts_cnt <= sts_cnt+1.
- Non-matching transfers leave sts_cnt unchanged: counts are cumulative, not consecutive.
- Latency: sts_trg is registered and asserts in the cycle after the clock edge that samples the completing transfer.
- cfg_cnt = 2**CNW-1: sts_cnt reaches all-ones and then completes. The counter never wraps.
- A stage advance takes effect on the next evaluated transfer. The completing sample is not re-evaluated by the next stage.
- sts_armed = (state == RUN).
- Transfers in IDLE or DONE update only dly_tdata.

Decomposition:
- Package trigger_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the slice helper localparams;
  - a function computing the bitwise hit vector.
- Sub-module trigger_stage_match (combinational, SDW param) takes d, c, the four masks and mode, and outputs match.
  - It is instantiated TSN times via generate.
  - The parent muxes the match by sts_stage.

Test Plan:
- TSN=1, cfg_cnt=0, cfg_0_1=0x1, OR.
  - Stimulus: arm, transfers 0x0, 0x1.
  - Response: no trigger on the first (priming) sample. sts_trg pulses in the cycle after the 0x1 edge. sts_done=1.
- TSN=2, stage0 level cfg_1_1=0xFF AND with cfg_cnt=2, stage1 rising bit 8.
  - Stimulus: three samples with 0xFF interleaved with 0x00, then bit 8 rises.
  - Response: stage advances only after the 3rd hit. sts_cnt goes 0,1,2. Trigger follows the bit 8 rise.
- Stimulus: ctl_arm and ctl_abort in the same cycle while RUN at stage 1.
  - Response: IDLE, sts_stage=0, sts_armed=0, no sts_trg.
- Stimulus: re-arm mid-sequence at stage 2 with sts_cnt=5.
  - Response: next cycle sts_stage=0, sts_cnt=0. The first following transfer only primes.
- Stimulus: rst_n asserted asynchronously mid-RUN, between clock edges.
  - Response: all outputs 0 immediately. After release, transfers are ignored until ctl_arm.
- CNW=4, cfg_cnt=15.
  - Stimulus: 16 matching transfers.
  - Response: completion on the 16th, no wrap, and no early trigger on transfers 1..15.
